// File: rtl/secmax_session_arbiter.sv
// secmax_session_arbiter: round-robin session arbiter reporting the largest and second-largest sample of each session.
module secmax_session_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_sec,
  output logic [DATA_WIDTH-1:0]         res_max,
  output logic [IDW-1:0]                res_id,
  output logic [15:0]                   res_count,
  output logic                          busy
);
  typedef enum logic [1:0] {IDLE, STREAM, RESULT} state_t;
  state_t                state_q, state_d;
  logic [IDW-1:0]        id_q, id_d, ptr_q, ptr_d, win, cand;
  logic [DATA_WIDTH-1:0] max_q, max_d, sec_q, sec_d, sample;
  logic [15:0]           cnt_q, cnt_d;
  logic                  found, acc;
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    max_d   = max_q;
    sec_d   = sec_q;
    cnt_d   = cnt_q;
    win     = ptr_q;
    cand    = ptr_q;
    found   = 1'b0;
    // Search upward from the slot after the last finished session, with wrap.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    sample = in_data[id_q*DATA_WIDTH +: DATA_WIDTH];
    acc    = (state_q == STREAM) && in_valid[id_q];
    if (state_q == IDLE && found) begin
      state_d = STREAM;
      id_d    = win;
      max_d   = '0;
      sec_d   = '0;
      cnt_d   = '0;
    end
    if (acc) begin
      if (sample >= max_q) begin
        sec_d = max_q;
        max_d = sample;
      end else if (sample > sec_q) begin
        sec_d = sample;
      end
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      if (in_last[id_q]) state_d = RESULT;
    end
    if (state_q == RESULT && res_ready) begin
      state_d = IDLE;
      ptr_d   = id_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= IDW'(NUM_REQ - 1);
      max_q   <= '0;
      sec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      max_q   <= max_d;
      sec_q   <= sec_d;
      cnt_q   <= cnt_d;
    end
  end
  assign gnt       = (state_q == STREAM) ? NUM_REQ'(1) << id_q : '0;
  assign in_ready  = gnt;
  assign res_valid = state_q == RESULT;
  assign busy      = state_q != IDLE;
  assign res_sec   = sec_q;
  assign res_max   = max_q;
  assign res_id    = id_q;
  assign res_count = cnt_q;
endmodule

// File: tb/tb_secmax_session_arbiter.sv
// tb_secmax_session_arbiter: table-driven sessions plus corner sequences, checked through an expected-result queue.
module tb_secmax_session_arbiter;
  logic         clk = 0, reset = 1, res_ready = 0;
  logic [3:0]   req = 0, in_valid = 0, in_last = 0, in_ready, gnt;
  logic [127:0] in_data = 0;
  logic         res_valid, busy;
  logic [31:0]  res_sec, res_max;
  logic [1:0]   res_id;
  logic [15:0]  res_count;
  int errors = 0, checks = 0;

  typedef struct packed {
    int              lane;
    int              n;
    logic [3:0][31:0] s;
    bit              bp;
    logic [31:0]     esec, emax;
    logic [15:0]     ecnt;
  } vec_t;
  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sec, mx;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  vec_t tbl[7];

  secmax_session_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .gnt(gnt), .res_valid(res_valid),
    .res_ready(res_ready), .res_sec(res_sec), .res_max(res_max), .res_id(res_id),
    .res_count(res_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0][31:0] pk(logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic do_session(int lane, int n, logic [3:0][31:0] s, logic [3:0] rq, bit bp,
                            logic [31:0] esec, logic [31:0] emax, logic [15:0] ecnt);
    int t;
    exp_t e;
    logic [3:0] lb;
    lb  = 4'(1 << lane);
    req = rq;
    t   = 0;
    do begin
      @(negedge clk);
      t++;
    end while (gnt == 0 && t < 20);
    chk("gnt", gnt, lb);
    chk("in_ready_stream", in_ready, lb);
    req = rq & ~lb;
    for (int k = 0; k < n; k++) begin
      in_valid = bp ? 4'hF : lb;
      in_data  = bp ? {128{1'b1}} : '0;
      in_data[lane*32 +: 32] = s[k % 4];
      in_last  = bp ? (4'hF & ~lb) : 4'h0;
      in_last[lane] = (k == n - 1);
      if (k == n - 1) q.push_back('{id: 2'(lane), sec: esec, mx: emax, cnt: ecnt});
      @(negedge clk);
    end
    in_valid = 0;
    in_last  = 0;
    t = 0;
    while (!res_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid", res_valid, 1);
    e = (q.size() != 0) ? q.pop_front() : '0;
    chk("res_id", res_id, e.id);
    chk("res_sec", res_sec, e.sec);
    chk("res_max", res_max, e.mx);
    chk("res_count", res_count, e.cnt);
    chk("gnt_result", gnt, 0);
    if (bp) begin
      req      = ~lb;
      in_valid = ~lb;
      in_last  = ~lb;
      in_data  = {128{1'b1}};
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("bp_valid", res_valid, 1);
        chk("bp_sec", res_sec, e.sec);
        chk("bp_max", res_max, e.mx);
        chk("bp_cnt", res_count, e.cnt);
        chk("bp_ready", in_ready, 0);
        chk("bp_gnt", gnt, 0);
      end
      in_valid = 0;
      in_last  = 0;
    end
    req       = 0;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("post_hs_valid", res_valid, 0);
    chk("post_hs_busy", busy, 0);
  endtask

  initial begin
    tbl[0] = '{lane: 1, n: 4, s: pk(5, 9, 3, 9), bp: 1, esec: 9, emax: 9, ecnt: 4};
    tbl[1] = '{lane: 0, n: 1, s: pk(42, 0, 0, 0), bp: 0, esec: 0, emax: 42, ecnt: 1};
    tbl[2] = '{lane: 3, n: 2, s: pk(7, 7, 0, 0), bp: 0, esec: 7, emax: 7, ecnt: 2};
    tbl[3] = '{lane: 2, n: 3, s: pk(1, 2, 3, 0), bp: 0, esec: 2, emax: 3, ecnt: 3};
    tbl[4] = '{lane: 0, n: 4, s: pk(10, 3, 8, 9), bp: 0, esec: 9, emax: 10, ecnt: 4};
    tbl[5] = '{lane: 1, n: 1, s: pk(0, 0, 0, 0), bp: 0, esec: 0, emax: 0, ecnt: 1};
    tbl[6] = '{lane: 3, n: 2, s: pk(32'hFFFF_FFFF, 5, 0, 0), bp: 1, esec: 5, emax: 32'hFFFF_FFFF, ecnt: 2};
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", res_valid, 0);
    // With every request held, grants rotate 0,1,2,3 and wrap.
    for (int i = 0; i < 5; i++)
      do_session(i % 4, 1, pk(100 + i, 0, 0, 0), 4'hF, 0, 0, 100 + i, 1);
    for (int i = 0; i < 7; i++)
      do_session(tbl[i].lane, tbl[i].n, tbl[i].s, 4'(1 << tbl[i].lane), tbl[i].bp,
                 tbl[i].esec, tbl[i].emax, tbl[i].ecnt);
    // Reset abandons an open lane-2 session.
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    chk("mid_gnt", gnt, 4'b0100);
    in_valid = 4'b0100;
    in_data[64 +: 32] = 8;
    @(negedge clk);
    in_data[64 +: 32] = 6;
    @(negedge clk);
    in_valid = 0;
    req      = 0;
    reset    = 1;
    @(negedge clk);
    reset = 0;
    chk("mid_busy", busy, 0);
    chk("mid_gnt0", gnt, 0);
    chk("mid_valid", res_valid, 0);
    do_session(1, 1, pk(11, 0, 0, 0), 4'b0110, 0, 0, 11, 1);
    do_session(2, 1, pk(4, 0, 0, 0), 4'b0100, 0, 0, 4, 1);
    do_session(0, 70000, pk(1, 2, 3, 4), 4'b0001, 0, 4, 4, 16'hFFFF);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/secmax_session_arbiter.md
SECMAX_SESSION_ARBITER -- requirements
Module: secmax_session_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: sample and result width in bits.
REQ-002 Parameter NUM_REQ, default 4: number of requesters; IDW = max(1, clog2(NUM_REQ)).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester session request, level-sensitive.
REQ-006 in_valid  input  NUM_REQ  per-requester sample valid.
REQ-007 in_data  input  NUM_REQ*DATA_WIDTH  per-requester unsigned sample; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 in_last  input  NUM_REQ  per-requester last-sample flag, qualified by in_valid.
REQ-009 in_ready  output  NUM_REQ  per-requester sample accept; at most one bit high.
REQ-010 gnt  output  NUM_REQ  one-hot session grant; all zero when no session is open.
REQ-011 res_valid  output  1  session result available.
REQ-012 res_ready  input  1  result consumer accept.
REQ-013 res_sec  output  DATA_WIDTH  second-largest sample of the finished session.
REQ-014 res_max  output  DATA_WIDTH  largest sample of the finished session.
REQ-015 res_id  output  IDW  index of the requester that owned the session.
REQ-016 res_count  output  16  number of samples accepted in the session, saturating at 65535.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states are IDLE, STREAM and RESULT.
REQ-019 IDLE: when any req bit is high, select one requester by round-robin, searching upward with wrap from (last granted index + 1); next cycle enter STREAM with gnt one-hot on the winner.
REQ-020 IDLE arbitration: clear tracker to max=0, sec=0, count=0 in the same edge that enters STREAM.
REQ-021 STREAM: in_ready[g]=1 for the granted index g only; all other in_ready bits SHALL be 0; in_ready SHALL be 0 in IDLE and RESULT.
REQ-022 Accepted sample = in_valid[g] & in_ready[g]; samples on non-granted lanes are ignored and SHALL NOT alter state.
REQ-023 Tracker update on an accepted sample d: if d >= max then sec<=max and max<=d; else if d > sec then sec<=d; otherwise no change.
REQ-024 Duplicate values count as separate candidates: samples 7,7 give sec=7.
REQ-025 A session with one accepted sample reports res_sec=0.
REQ-026 Each accepted sample increments count by 1; at 65535, count holds.
REQ-027 An accepted sample with in_last[g]=1 is included in the tracker; the FSM then enters RESULT on the next edge; gnt clears at that edge.
REQ-028 Deasserting req[g] during STREAM SHALL NOT end the session; only an accepted last sample ends it.
REQ-029 RESULT: res_valid=1; res_sec, res_max, res_id and res_count are held stable while res_valid=1 and res_ready=0.
REQ-030 RESULT: on res_valid & res_ready, latch the round-robin pointer to res_id and return to IDLE; the next grant is issued no earlier than 2 cycles after the handshake.
REQ-031 res_valid SHALL be 0 outside RESULT; res_* values outside RESULT are don't-care.
REQ-032 Fairness: with all req bits held high, successive sessions are granted 0,1,2,...,NUM_REQ-1,0,...

Reset
REQ-033 With reset high at an edge: state becomes IDLE, gnt=0, in_ready=0, res_valid=0, busy=0, max=sec=count=0, and the round-robin pointer is set so requester 0 wins the next arbitration.
REQ-034 Reset during STREAM or RESULT abandons the session; no result is produced, and the abandoned requester has no priority advantage.

Verification
REQ-035 Single session: req[1]=1, samples 5,9,3,9(last) on lane 1 -> gnt=0010 the cycle after req; result res_sec=9, res_max=9, res_id=1, res_count=4.
REQ-036 One-sample session: lane 0 sends 42(last) -> res_sec=0, res_max=42, res_count=1.
REQ-037 Round-robin: all req high; each session sends 1 sample (last) -> res_id sequence 0,1,2,3,0.
REQ-038 Backpressure and isolation: res_ready=0 for 5 cycles while other lanes drive in_valid with 0xFFFFFFFF -> res_* stable, in_ready=0, tracker unchanged, and no new grant until the handshake.
REQ-039 Reset mid-session: lane 2 sends 8,6, then reset for 1 cycle -> next cycle busy=0 and gnt=0; a new lane 2 session sending 4(last) reports res_sec=0, res_max=4.
REQ-040 Saturation: 70000 samples (last on final sample) -> res_count=65535.
